// File: rtl/riscv_iter_shifter.sv
// Multi-cycle SLL/SRL/SRA unit: shifts a latched operand by up to STEP bits per clock
// so wide operands never need a full-width single-cycle barrel shifter.
module riscv_iter_shifter #(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    // Bits needed to express a per-edge step of 0..STEP.
    localparam int K_W = $clog2(STEP + 1);

    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]   acc_next;
    logic [SHAMT_W-1:0] rem_reg;
    logic [SHAMT_W-1:0] rem_next;
    logic [1:0]         op_reg;
    logic [1:0]         op_next;
    logic               sign_reg;
    logic               sign_next;
    logic [WIDTH-1:0]   result_reg;
    logic [WIDTH-1:0]   result_next;
    logic               accept;

    // Amount shifted on this edge: the whole remainder once it fits in one step.
    logic [K_W-1:0] k_amt;
    assign k_amt = (32'(rem_reg) < 32'(STEP)) ? K_W'(rem_reg) : K_W'(STEP);

    // Log-structured step shifter: stage gi conditionally moves by 2**gi.
    logic [WIDTH-1:0] stage [0:K_W];
    assign stage[0] = acc_reg;

    genvar gi;
    generate
        for (gi = 0; gi < K_W; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            logic [WIDTH-1:0] fill;
            logic [WIDTH-1:0] moved;

            assign fill = ~({WIDTH{1'b1}} >> SH);

            always_comb begin
                case (op_reg)
                    OP_SRL:  moved = stage[gi] >> SH;
                    OP_SRA:  moved = (stage[gi] >> SH) | (sign_reg ? fill : '0);
                    default: moved = stage[gi] << SH;
                endcase
            end

            assign stage[gi+1] = k_amt[gi] ? moved : stage[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        rem_next    = rem_reg;
        op_next     = op_reg;
        sign_next   = sign_reg;
        result_next = result_reg;
        ready       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;

        case (state_reg)
            IDLE: begin
                ready  = 1'b1;
                accept = start;
            end
            SHIFT: begin
                busy     = 1'b1;
                acc_next = stage[K_W];
                rem_next = rem_reg - SHAMT_W'(k_amt);
                if (rem_next == '0) begin
                    result_next = stage[K_W];
                    state_next  = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                ready      = 1'b1;
                accept     = start;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Acceptance from DONE overrides the return to IDLE for back-to-back issue.
        if (accept) begin
            op_next   = op;
            acc_next  = a;
            rem_next  = shamt;
            sign_next = a[WIDTH-1];
            if (shamt == '0) begin
                result_next = a;
                state_next  = DONE;
            end else begin
                state_next  = SHIFT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg    <= '0;
            rem_reg    <= '0;
            op_reg     <= '0;
            sign_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            acc_reg    <= acc_next;
            rem_reg    <= rem_next;
            op_reg     <= op_next;
            sign_reg   <= sign_next;
            result_reg <= result_next;
        end
    end

    assign result = result_reg;

endmodule

// File: tb/tb_riscv_iter_shifter.sv
// Bench for riscv_iter_shifter: three configurations (32/1, 32/4, 64/8) checked against
// directed vectors, an arithmetic reference model and multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_riscv_iter_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic        start_v [3];
    logic [1:0]  op_v    [3];
    logic [63:0] a_v     [3];
    logic [5:0]  shamt_v [3];
    logic        ready_v [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [31:0] res0;
    logic [31:0] res1;
    logic [63:0] res2;

    int tests = 0;
    int fails = 0;
    int proto_err = 0;

    int width_of [3] = '{32, 32, 64};
    int step_of  [3] = '{1, 4, 8};

    riscv_iter_shifter #(.WIDTH(32), .STEP(1)) dut (
        .clk(clk), .rst(rst), .start(start_v[0]), .op(op_v[0]),
        .a(a_v[0][31:0]), .shamt(shamt_v[0][4:0]),
        .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .result(res0)
    );

    riscv_iter_shifter #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .op(op_v[1]),
        .a(a_v[1][31:0]), .shamt(shamt_v[1][4:0]),
        .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .result(res1)
    );

    riscv_iter_shifter #(.WIDTH(64), .STEP(8)) dut64 (
        .clk(clk), .rst(rst), .start(start_v[2]), .op(op_v[2]),
        .a(a_v[2]), .shamt(shamt_v[2]),
        .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .result(res2)
    );

    typedef struct {
        int          sel;
        logic [1:0]  op;
        logic [63:0] a;
        int          s;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [63:0] result_of(input int sel);
        case (sel)
            0:       return {32'd0, res0};
            1:       return {32'd0, res1};
            default: return res2;
        endcase
    endfunction

    // RISC-V shift semantics on a w-bit value; SRA fills the vacated top bits with the sign.
    function automatic logic [63:0] model(input int w, input logic [1:0] op,
                                          input logic [63:0] a, input int s);
        logic [63:0] mask;
        logic [63:0] av;
        logic [63:0] r;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        av   = a & mask;
        case (op)
            2'b01: r = av >> s;
            2'b11: begin
                r = av >> s;
                if (av[w-1]) r = r | (mask & ~(mask >> s));
            end
            default: r = (av << s) & mask;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after an accept edge; counts further edges until done is seen.
    task automatic wait_done(input int sel, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (done_v[sel] && busy_v[sel]) proto_err++;
            if (busy_v[sel] == ready_v[sel]) proto_err++;
            if (done_v[sel]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_op(input int sel, input logic [1:0] op, input logic [63:0] a,
                         input int s, output logic [63:0] res, output int lat);
        bit ok;
        int g;
        @(negedge clk);
        g = 0;
        while (!ready_v[sel] && g < 300) begin
            @(negedge clk);
            g++;
        end
        start_v[sel] = 1'b1;
        op_v[sel]    = op;
        a_v[sel]     = a;
        shamt_v[sel] = 6'(s);
        @(posedge clk);
        #1;
        // Scramble operands right after accept; the in-flight op must not notice.
        start_v[sel] = 1'b0;
        op_v[sel]    = ~op;
        a_v[sel]     = ~a;
        shamt_v[sel] = ~shamt_v[sel];
        wait_done(sel, lat, ok);
        check($sformatf("done_seen[%0d]", sel), 64'(ok), 64'd1);
        res = result_of(sel);
        $display("[TB] cfg=%0d op=%b a=0x%0h s=%0d -> result=0x%0h latency=%0d",
                 sel, op, a, s, res, lat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res;
        int          lat;
        int          n;
        bit          ok;
        int          seen;

        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            op_v[i]    = 2'b00;
            a_v[i]     = '0;
            shamt_v[i] = '0;
        end

        vecs[0]  = '{0, 2'b01, 64'h0000_00f0, 4, 64'h0000_000f, 4};
        vecs[1]  = '{0, 2'b01, 64'h0, 4, 64'h0, 4};
        vecs[2]  = '{1, 2'b11, 64'h8000_0000, 31, 64'hffff_ffff, 8};
        vecs[3]  = '{1, 2'b01, 64'h8000_0000, 31, 64'h0000_0001, 8};
        vecs[4]  = '{0, 2'b00, 64'h1234_5678, 0, 64'h1234_5678, 0};
        vecs[5]  = '{0, 2'b00, 64'h1234_5678, 1, 64'h2468_acf0, 1};
        vecs[6]  = '{2, 2'b00, 64'h1, 63, 64'h8000_0000_0000_0000, 8};
        vecs[7]  = '{0, 2'b10, 64'h1, 3, 64'h8, 3};
        vecs[8]  = '{1, 2'b00, 64'h1, 31, 64'h8000_0000, 8};
        vecs[9]  = '{2, 2'b11, 64'h8000_0000_0000_0000, 63, 64'hffff_ffff_ffff_ffff, 8};
        vecs[10] = '{1, 2'b11, 64'h7fff_ffff, 5, 64'h03ff_ffff, 2};
        vecs[11] = '{2, 2'b01, 64'hffff_ffff_ffff_ffff, 9, 64'h007f_ffff_ffff_ffff, 2};
        vecs[12] = '{1, 2'b11, 64'hf000_0000, 3, 64'hfe00_0000, 1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_ready[%0d]", i), 64'(ready_v[i]), 64'd1);
            check($sformatf("reset_busy[%0d]", i), 64'(busy_v[i]), 64'd0);
            check($sformatf("reset_done[%0d]", i), 64'(done_v[i]), 64'd0);
            check($sformatf("reset_result[%0d]", i), result_of(i), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].s, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        for (int i = 0; i < 60; i++) begin
            int          sel;
            int          w;
            int          s;
            logic [1:0]  op;
            logic [63:0] a;
            sel = i % 3;
            w   = width_of[sel];
            s   = (i % 7 == 0) ? w - 1 : int'($urandom_range(0, w - 1));
            op  = 2'($urandom);
            a   = {$urandom, $urandom};
            do_op(sel, op, a, s, res, lat);
            check($sformatf("rand%0d_result", i), res, model(w, op, a, s));
            check($sformatf("rand%0d_latency", i), 64'(lat),
                  64'((s + step_of[sel] - 1) / step_of[sel]));
        end

        // Start pulsed mid-shift is ignored; start in the DONE cycle is taken at once.
        @(negedge clk);
        start_v[0] = 1'b1; op_v[0] = 2'b01; a_v[0] = 64'hffff_0000; shamt_v[0] = 6'd16;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1; op_v[0] = 2'b00; a_v[0] = 64'h1; shamt_v[0] = 6'd3;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        check("ignored_start_busy", 64'(busy_v[0]), 64'd1);
        wait_done(0, n, ok);
        check("t4_done_seen", 64'(ok), 64'd1);
        check("t4_latency", 64'(n + 1), 64'd16);
        check("t4_result", result_of(0), 64'h0000_ffff);
        $display("[TB] cfg=0 op=01 a=0xffff0000 s=16 with mid-shift start -> result=0x%0h", result_of(0));
        start_v[0] = 1'b1; op_v[0] = 2'b00; a_v[0] = 64'h3; shamt_v[0] = 6'd2;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        check("b2b_busy", 64'(busy_v[0]), 64'd1);
        wait_done(0, n, ok);
        check("b2b_done_seen", 64'(ok), 64'd1);
        check("b2b_latency", 64'(n), 64'd2);
        check("b2b_result", result_of(0), 64'hc);
        $display("[TB] cfg=0 op=00 a=0x3 s=2 back-to-back -> result=0x%0h", result_of(0));

        // Reset at E0+5 of a 20-bit SLL discards it without a done pulse.
        @(negedge clk);
        start_v[0] = 1'b1; op_v[0] = 2'b00; a_v[0] = 64'h5; shamt_v[0] = 6'd20;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_result", result_of(0), 64'd0);
        check("midrst_busy", 64'(busy_v[0]), 64'd0);
        check("midrst_ready", 64'(ready_v[0]), 64'd1);
        check("midrst_done", 64'(done_v[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_v[0]) seen++;
        end
        check("midrst_no_done", 64'(seen), 64'd0);
        $display("[TB] cfg=0 op=00 a=0x5 s=20 reset at E0+5 -> done pulses=%0d", seen);
        do_op(0, 2'b01, 64'h100, 8, res, lat);
        check("post_rst_result", res, 64'h1);
        check("post_rst_latency", 64'(lat), 64'd8);

        check("protocol_busy_done_ready", 64'(proto_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_iter_shifter.md
Name: riscv_iter_shifter

Overview:
- Multi-cycle shift unit for the RISC-V datapath, executing SLL/SRL/SRA (register and immediate forms) over several clocks.
- Replaces the single-cycle combinational ALU shift path, so larger WIDTH values do not lengthen the critical path.
- Sits beside the ALU. The multicycle control FSM starts it with start, stalls on busy, and writes result to the register file on done.
- Width and bits-shifted-per-cycle are parametrised.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, 8..64.
- STEP, 1, maximum bits shifted per clock; power of two, 1..WIDTH.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, must not be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only while ready=1.
- op  in  2  00=SLL, 01=SRL, 11=SRA, 10=reserved (executes as SLL).
- a  in  WIDTH  operand to shift (rs1).
- shamt  in  SHAMT_W  shift amount; only the low SHAMT_W bits of rs2/imm are connected.
- ready  out  1  unit can accept start (state IDLE or DONE).
- busy  out  1  shift in progress (state SHIFT).
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  registered shift result; held until the next completion.

Behaviour:
- Clocking and reset:
  - One clock, clk; everything updates on the rising edge.
  - rst=1 at any edge, including mid-operation: state->IDLE, result=0, done=0, busy=0, ready=1.
  - An in-flight operation is discarded and produces no done.
- States:
  - IDLE: ready=1. start=1 latches op, a into acc and shamt into rem. Next state is SHIFT if shamt!=0, else DONE with result=a.
  - SHIFT: busy=1, ready=0, and start is ignored. Each edge shifts acc by k=min(STEP, rem) and sets rem-=k.
    - SLL fills zeros from the LSB.
    - SRL fills zeros from the MSB.
    - SRA replicates the latched a[WIDTH-1].
    - When rem reaches 0 on an edge, result<=shifted acc and next state is DONE.
  - DONE: done=1, ready=1, busy=0 for exactly one cycle.
    - start=1 here is accepted exactly as in IDLE, giving back-to-back operation with no idle bubble.
    - Otherwise next state is IDLE.
- Latency:
  - Accept edge E0. done is high in the cycle following edge E0+ceil(s/STEP), where s=shamt.
  - s=0 gives done in the cycle right after E0.
  - Throughput: one operation per ceil(s/STEP)+1 cycles at most.
- Operand stability: a, op and shamt are captured at accept; later changes have no effect on the in-flight operation.
- Arithmetic:
  - Results match RISC-V RV32/RV64 semantics for the masked shamt.
  - SRA by WIDTH-1 of a negative value gives all ones.
  - SLL/SRL by WIDTH-1 leave a single surviving bit.
- Partial final step: when rem<STEP, only rem bits are shifted on that edge, never more.
- done and busy are never high in the same cycle. ready = !busy.

Test Plan:
1. WIDTH=32, STEP=1. Preload x0/x4/x5/x6 style values, then SRL a=0xf0, shamt=4 -> done after edge E0+4, result=0x0f. A follow-up SRL a=0, shamt=4 -> result=0.
2. WIDTH=32, STEP=4, SRA a=0x80000000, shamt=31 -> busy for 8 cycles, done after edge E0+8, result=0xffffffff. Same inputs with SRL -> result=0x00000001.
3. SLL a=0x12345678, shamt=0 -> done in the cycle after E0, result=0x12345678, busy never asserted. SLL shamt=1 (STEP=1) -> result=0x2468acf0.
4. Start SRL a=0xffff0000, shamt=16 (STEP=1). Pulse start with different operands during SHIFT -> ignored; result=0x0000ffff. Assert start with a new op in the DONE cycle -> accepted with no IDLE cycle.
5. Start SLL shamt=20. Assert rst for one cycle at edge E0+5 -> result=0, busy=0, ready=1, and no done pulse follows. A new operation afterwards completes correctly.
6. WIDTH=64, STEP=8, SLL a=1, shamt=63 -> done after edge E0+8, result=0x8000000000000000.
7. op=10 with a=1, shamt=3 -> result=8.
